// File: rtl/jalu_seq.sv
// ----------------------------------------------------------------------------
// jalu_seq -- multi-byte sequencer for the 8-bit ALU datapath.
//
// Runs one ALU operation over an operand of 1..MAXB bytes, one byte per
// clock. It picks the byte order for the operation, chains the carry/shift
// bit from byte to byte, folds the per-byte compare results into a
// word-level compare, strobes result write-back, and latches the final flags.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   start, op, len, ci    operation request (start sampled only while ready)
//   alu_op, alu_ci, idx   drive to the ALU and the byte-addressed operand regs
//   alu_co/eq/al/z        per-byte ALU results (combinational from idx)
//   wr_en                 write ALU result byte to result[idx] this cycle
//   ready, done           idle indicator / one-cycle completion pulse
//   f_co/f_eq/f_al/f_z    final flags, valid from done until the next op ends
// ----------------------------------------------------------------------------
module jalu_seq #(
   parameter int MAXB = 4,
   parameter int IW   = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [2:0]    op,
   input  logic [IW-1:0] len,
   input  logic          ci,
   output logic [2:0]    alu_op,
   output logic          alu_ci,
   output logic [IW-1:0] idx,
   input  logic          alu_co,
   input  logic          alu_eq,
   input  logic          alu_al,
   input  logic          alu_z,
   output logic          wr_en,
   output logic          ready,
   output logic          done,
   output logic          f_co,
   output logic          f_eq,
   output logic          f_al,
   output logic          f_z
);

   // The byte index must exactly cover the operand length.
   if (MAXB != (1 << IW)) begin : g_bad_param
      $error("jalu_seq: MAXB must equal 2**IW");
   end

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SHR = 3'b001;
   localparam logic [2:0] OP_SHL = 3'b010;
   localparam logic [2:0] OP_CMP = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_FIN  = 2'b10
   } state_t;

   state_t        state_q;
   logic [2:0]    op_q;
   logic [IW-1:0] cnt_q;       // bytes remaining after the current one
   logic [IW-1:0] idx_q;
   logic          alu_ci_q;
   logic          eq_acc_q;
   logic          al_acc_q;
   logic          z_acc_q;
   logic          wr_en_q;
   logic          ready_q;
   logic          done_q;
   logic          f_co_q;
   logic          f_eq_q;
   logic          f_al_q;
   logic          f_z_q;

   logic          chained_s;     // running op passes a bit between bytes
   logic          desc_s;        // running op walks from LSB byte upward
   logic          is_cmp_s;
   logic          start_chain_s; // same decisions for the op being started
   logic          start_desc_s;
   logic          last_s;
   logic [IW-1:0] idx_d;
   logic          eq_acc_d;
   logic          al_acc_d;
   logic          z_acc_d;

   // Per-byte decode and accumulator next values.
   always_comb begin
      chained_s     = (op_q == OP_ADD) || (op_q == OP_SHR) || (op_q == OP_SHL);
      desc_s        = (op_q == OP_ADD) || (op_q == OP_SHL);
      is_cmp_s      = (op_q == OP_CMP);
      start_chain_s = (op == OP_ADD) || (op == OP_SHR) || (op == OP_SHL);
      start_desc_s  = (op == OP_ADD) || (op == OP_SHL);
      last_s        = (cnt_q == '0);
      if (desc_s) begin
         idx_d = idx_q - 1'b1;
      end else begin
         idx_d = idx_q + 1'b1;
      end
      // The a-larger verdict is taken from the first (most significant)
      // differing byte; once bytes differ, later bytes cannot change it.
      eq_acc_d = eq_acc_q & alu_eq;
      if (eq_acc_q) begin
         al_acc_d = alu_al;
      end else begin
         al_acc_d = al_acc_q;
      end
      z_acc_d = z_acc_q & alu_z;
   end

   // Sequencer FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         op_q     <= 3'b000;
         cnt_q    <= '0;
         idx_q    <= '0;
         alu_ci_q <= 1'b0;
         eq_acc_q <= 1'b1;
         al_acc_q <= 1'b0;
         z_acc_q  <= 1'b1;
         wr_en_q  <= 1'b0;
         ready_q  <= 1'b1;
         done_q   <= 1'b0;
         f_co_q   <= 1'b0;
         f_eq_q   <= 1'b0;
         f_al_q   <= 1'b0;
         f_z_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  op_q     <= op;
                  cnt_q    <= len;
                  idx_q    <= start_desc_s ? len : '0;
                  alu_ci_q <= start_chain_s ? ci : 1'b0;
                  eq_acc_q <= 1'b1;
                  al_acc_q <= 1'b0;
                  z_acc_q  <= 1'b1;
                  wr_en_q  <= (op != OP_CMP);
                  ready_q  <= 1'b0;
                  state_q  <= S_RUN;
               end else begin
                  ready_q  <= 1'b1;
               end
            end
            S_RUN: begin
               eq_acc_q <= eq_acc_d;
               al_acc_q <= al_acc_d;
               z_acc_q  <= z_acc_d;
               alu_ci_q <= chained_s ? alu_co : 1'b0;
               if (last_s) begin
                  // Final byte: flags come from this byte's live ALU outputs.
                  wr_en_q <= 1'b0;
                  done_q  <= 1'b1;
                  f_co_q  <= chained_s ? alu_co : 1'b0;
                  f_eq_q  <= is_cmp_s ? eq_acc_d : 1'b0;
                  f_al_q  <= is_cmp_s ? al_acc_d : 1'b0;
                  f_z_q   <= z_acc_d;
                  state_q <= S_FIN;
               end else begin
                  idx_q   <= idx_d;
                  cnt_q   <= cnt_q - 1'b1;
               end
            end
            S_FIN: begin
               done_q  <= 1'b0;
               ready_q <= 1'b1;
               state_q <= S_IDLE;
            end
            default: begin
               wr_en_q <= 1'b0;
               done_q  <= 1'b0;
               ready_q <= 1'b1;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign alu_op = op_q;
   assign alu_ci = alu_ci_q;
   assign idx    = idx_q;
   assign wr_en  = wr_en_q;
   assign ready  = ready_q;
   assign done   = done_q;
   assign f_co   = f_co_q;
   assign f_eq   = f_eq_q;
   assign f_al   = f_al_q;
   assign f_z    = f_z_q;

endmodule
